// File: rtl/speed_select_ctrl_if.sv
// Button / selector bundle between the user-input front end and the slow-clock divider.
//
// Signals:
//   btn_in        raw push-button level, asynchronous, active-high, bouncy
//   clk_selector  2-bit registered speed selection towards the divider
//   sel_changed   one-cycle pulse in the cycle clk_selector takes a new value
//   btn_level     debounced button level
//
// Modports:
//   master  drives btn_in, observes the selector outputs (button side / testbench)
//   slave   receives btn_in, drives the selector outputs (speed_select_ctrl)
interface speed_select_ctrl_if;
    logic       btn_in;
    logic [1:0] clk_selector;
    logic       sel_changed;
    logic       btn_level;

    modport master (
        output btn_in,
        input  clk_selector,
        input  sel_changed,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output clk_selector,
        output sel_changed,
        output btn_level
    );
endinterface

// File: rtl/speed_select_ctrl.sv
// Speed-select front end: synchronizes and debounces a raw push-button and steps the 2-bit
// divider selection 00 -> 01 -> 10 -> 11 -> 00 once per debounced press.
//
// Ports:
//   clk_10MHz  10 MHz system clock
//   rstn       asynchronous active-low reset
//   bus_io     speed_select_ctrl_if.slave (btn_in in; clk_selector, sel_changed, btn_level out)
//
// Parameters:
//   DEBOUNCE_CYCLES    consecutive synchronized samples (after the first) needed to accept a
//                      press or a release; must be >= 2
//   DEFAULT_SEL        selector value after reset (and after a long press, if enabled)
//   LONG_PRESS_CYCLES  hold time in HELD_HIGH before the selector returns to DEFAULT_SEL
//
// Optional feature: define SPEED_SEL_LONG_PRESS_EN to enable the long-press return to
// DEFAULT_SEL. Without it, HELD_HIGH only waits for the release.
module speed_select_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 100000,
    parameter logic [1:0]  DEFAULT_SEL       = 2'b00,
    parameter int unsigned LONG_PRESS_CYCLES = 20000000
) (
    input logic                clk_10MHz,
    input logic                rstn,
    speed_select_ctrl_if.slave bus_io
);

    // One counter serves both the debounce windows and the long-press hold time.
    localparam int unsigned CntMax =
        (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_CYCLES);
`ifdef SPEED_SEL_LONG_PRESS_EN
    localparam logic [CntW-1:0] LongMax = CntW'(LONG_PRESS_CYCLES);
`endif

    typedef enum logic [1:0] {
        StIdleLow,
        StChkHigh,
        StHeldHigh,
        StChkLow
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            sync1_q;
    logic            sync2_q;
    logic [1:0]      sel_q;
    logic            changed_q;
    logic            level_q;
    logic            btn_s;

    assign btn_s = sync2_q;

    always_ff @(posedge clk_10MHz or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdleLow;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sel_q     <= DEFAULT_SEL;
            changed_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= bus_io.btn_in;
            sync2_q   <= sync1_q;
            // Pulse only in the cycle an event is taken.
            changed_q <= 1'b0;

            unique case (state_q)
                StIdleLow: begin
                    if (btn_s) begin
                        state_q <= StChkHigh;
                        cnt_q   <= CntW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end

                StChkHigh: begin
                    if (!btn_s) begin
                        // Bounce: drop the candidate press without any event.
                        state_q <= StIdleLow;
                        cnt_q   <= '0;
                    end else if (cnt_q == DebMax) begin
                        state_q   <= StHeldHigh;
                        cnt_q     <= '0;
                        level_q   <= 1'b1;
                        sel_q     <= sel_q + 2'd1;
                        changed_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StHeldHigh: begin
                    if (!btn_s) begin
                        state_q <= StChkLow;
                        cnt_q   <= CntW'(1);
                    end
`ifdef SPEED_SEL_LONG_PRESS_EN
                    else if (cnt_q == LongMax - CntW'(1)) begin
                        // Fires even if the selector already holds DEFAULT_SEL; the counter
                        // then parks at LongMax so this happens once per press.
                        cnt_q     <= LongMax;
                        sel_q     <= DEFAULT_SEL;
                        changed_q <= 1'b1;
                    end else if (cnt_q != LongMax) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end

                StChkLow: begin
                    if (btn_s) begin
                        // Release bounce: back to held, hold time restarts.
                        state_q <= StHeldHigh;
                        cnt_q   <= '0;
                    end else if (cnt_q == DebMax) begin
                        state_q <= StIdleLow;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                default: begin
                    state_q <= StIdleLow;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus_io.clk_selector = sel_q;
    assign bus_io.sel_changed  = changed_q;
    assign bus_io.btn_level    = level_q;

endmodule

// File: tb/tb_speed_select_ctrl.sv
// Self-checking bench for speed_select_ctrl (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20,
// DEFAULT_SEL=00). Expected selector pulses (cycle, value) are queued when a press is driven
// and popped when sel_changed is seen; a table of press shapes drives the main cases and
// hand-written sequences cover release bounce, reset mid-debounce and the long hold.
module tb_speed_select_ctrl;

    localparam int unsigned Deb     = 4;
    localparam int unsigned LongP   = 20;
    localparam logic [1:0]  DefSel  = 2'b00;
    // btn_in change to selector update: 2 sync edges + Deb + 1 edges.
    localparam int          Latency = 2 + Deb + 1;

    logic clk;
    logic rstn;

    speed_select_ctrl_if bus ();

    speed_select_ctrl #(
        .DEBOUNCE_CYCLES   (Deb),
        .DEFAULT_SEL       (DefSel),
        .LONG_PRESS_CYCLES (LongP)
    ) dut (
        .clk_10MHz (clk),
        .rstn      (rstn),
        .bus_io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
    } exp_t;

    typedef struct {
        bit         rst_before;
        int         hi;
        int         lo;
        bit         ev;
        logic [1:0] sel;
        bit         lvl_hi;
        bit         lvl_lo;
        string      name;
    } vec_t;

    exp_t exp_q[$];
    vec_t tab[9];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [1:0] sel);
        exp_t e;
        e.cyc = at;
        e.sel = sel;
        exp_q.push_back(e);
    endtask

    // Advance one clock and sample #1 after the edge; scoreboard the sel_changed pulses.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            n_fail++;
            $display("FAIL missing_pulse: got no sel_changed at cycle %0d, required pulse to %0d",
                     e.cyc, e.sel);
        end
        if (bus.sel_changed === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL extra_pulse: got sel_changed=1 sel=%0d at cycle %0d, required none",
                         bus.clk_selector, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_sel", {30'd0, bus.clk_selector}, {30'd0, e.sel});
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_sel", {30'd0, bus.clk_selector}, {30'd0, DefSel});
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        //               rst  hi  lo  ev  sel    lvl_hi lvl_lo name
        tab[0] = '{1'b0, 30, 20, 1'b1, 2'b01, 1'b1, 1'b0, "single_press"};
        tab[1] = '{1'b0,  3,  1, 1'b0, 2'b01, 1'b0, 1'b0, "bounce_a"};
        tab[2] = '{1'b0,  3, 10, 1'b0, 2'b01, 1'b0, 1'b0, "bounce_b"};
        tab[3] = '{1'b0,  4, 10, 1'b0, 2'b01, 1'b0, 1'b0, "short_4"};
        tab[4] = '{1'b0,  5, 10, 1'b1, 2'b10, 1'b0, 1'b0, "min_5"};
        tab[5] = '{1'b1, 10, 10, 1'b1, 2'b01, 1'b1, 1'b0, "clean_1"};
        tab[6] = '{1'b0, 10, 10, 1'b1, 2'b10, 1'b1, 1'b0, "clean_2"};
        tab[7] = '{1'b0, 10, 10, 1'b1, 2'b11, 1'b1, 1'b0, "clean_3"};
        tab[8] = '{1'b0, 10, 10, 1'b1, 2'b00, 1'b1, 1'b0, "clean_wrap"};

        rstn       = 1'b0;
        bus.btn_in = 1'b0;
        step(3);
        check("reset_sel", {30'd0, bus.clk_selector}, {30'd0, DefSel});
        check("reset_changed", {31'd0, bus.sel_changed}, 32'd0);
        check("reset_level", {31'd0, bus.btn_level}, 32'd0);
        rstn = 1'b1;
        tick();

        // Table-driven presses.
        for (int i = 0; i < 9; i++) begin
            if (tab[i].rst_before) do_reset();
            bus.btn_in = 1'b1;
            if (tab[i].ev) expect_pulse(cyc + Latency, tab[i].sel);
            step(tab[i].hi);
            check({tab[i].name, "_lvl_hi"}, {31'd0, bus.btn_level}, {31'd0, tab[i].lvl_hi});
            bus.btn_in = 1'b0;
            step(tab[i].lo);
            check({tab[i].name, "_lvl_lo"}, {31'd0, bus.btn_level}, {31'd0, tab[i].lvl_lo});
            check({tab[i].name, "_sel"}, {30'd0, bus.clk_selector}, {30'd0, tab[i].sel});
        end
        check("table_queue_empty", exp_q.size(), 32'd0);

        // Release bounce: glitches of 2 and 4 low samples must not release or step.
        bus.btn_in = 1'b1;
        expect_pulse(cyc + Latency, 2'b01);
        step(10);
        check("glitch_lvl_pressed", {31'd0, bus.btn_level}, 32'd1);
        bus.btn_in = 1'b0; step(2);
        bus.btn_in = 1'b1; step(2);
        bus.btn_in = 1'b0; step(4);
        bus.btn_in = 1'b1; step(2);
        check("glitch_lvl_held", {31'd0, bus.btn_level}, 32'd1);
        bus.btn_in = 1'b0;
        step(Latency - 1);
        check("release_lvl_early", {31'd0, bus.btn_level}, 32'd1);
        tick();
        check("release_lvl_fall", {31'd0, bus.btn_level}, 32'd0);
        step(5);
        check("glitch_sel", {30'd0, bus.clk_selector}, 32'd1);

        // Reset at count 3 of CHK_HIGH with the button still held through release.
        bus.btn_in = 1'b1;
        step(5);
        rstn = 1'b0;
        #1;
        check("midrst_sel", {30'd0, bus.clk_selector}, {30'd0, DefSel});
        check("midrst_level", {31'd0, bus.btn_level}, 32'd0);
        step(3);
        check("midrst_sel_held", {30'd0, bus.clk_selector}, {30'd0, DefSel});
        rstn = 1'b1;
        expect_pulse(cyc + Latency, DefSel + 2'd1);
        step(12);
        check("midrst_sel_after", {30'd0, bus.clk_selector}, 32'd1);
        bus.btn_in = 1'b0;
        step(10);

        // Advance to 10, then hold 40 cycles.
        bus.btn_in = 1'b1;
        expect_pulse(cyc + Latency, 2'b10);
        step(10);
        bus.btn_in = 1'b0;
        step(10);
        bus.btn_in = 1'b1;
        expect_pulse(cyc + Latency, 2'b11);
`ifdef SPEED_SEL_LONG_PRESS_EN
        expect_pulse(cyc + Latency + LongP, DefSel);
`endif
        step(40);
        bus.btn_in = 1'b0;
        step(15);
`ifdef SPEED_SEL_LONG_PRESS_EN
        check("long_sel", {30'd0, bus.clk_selector}, {30'd0, DefSel});
`else
        check("long_sel", {30'd0, bus.clk_selector}, 32'd3);
`endif
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/speed_select_ctrl.md
Name: speed_select_ctrl

Overview:
- Front-end control stage that drives the 2-bit `clk_selector` input of the slow-clock divider.
- Runs on the 10 MHz system clock.
- Synchronizes and debounces a raw push-button.
- Each debounced press advances the speed selection 00→01→10→11→00, so the user steps through 1 Hz, 2 Hz, 10 Hz and 0.5 Hz.

Parameters:
- DEBOUNCE_CYCLES, 100000, cycles `btn_s` must stay high after the first high sample before a press is accepted (10 ms at 10 MHz); also used for release; must be ≥2.
- DEFAULT_SEL, 2'b00, value loaded into `clk_selector` at reset (and on long press, if enabled).
- LONG_PRESS_CYCLES, 20000000, hold time for the long-press feature (2 s); ignored when the feature is compiled out.

Ports:
- clk_10MHz  input  1  system clock, 10 MHz
- rstn  input  1  asynchronous active-low reset
- btn_in  input  1  raw push-button, asynchronous, active-high, bouncy
- clk_selector  output  2  registered speed selection to the divider
- sel_changed  output  1  one-cycle pulse, high in the cycle `clk_selector` takes a new value
- btn_level  output  1  debounced button level

Behaviour:
- **Synchronizer:** two flip-flops on `btn_in`, both reset to 0; the output is `btn_s`.
- **Counter:** one internal counter, wide enough for max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES); never wraps.
- **FSM states:** IDLE_LOW, CHK_HIGH, HELD_HIGH, CHK_LOW. Reset state is IDLE_LOW.
- IDLE_LOW: if `btn_s`=1, go to CHK_HIGH with count<=1; otherwise stay, count=0.
- CHK_HIGH:
  - If `btn_s`=0, go to IDLE_LOW with count<=0 (bounce is rejected, no event).
  - Else if count==DEBOUNCE_CYCLES, go to HELD_HIGH with count<=0. In the same edge: `btn_level`<=1, `clk_selector`<=`clk_selector`+1 (modulo 4, 11 wraps to 00), `sel_changed`<=1.
  - Else count++.
- HELD_HIGH: if `btn_s`=0, go to CHK_LOW with count<=1; otherwise stay (see Optional Feature).
- CHK_LOW:
  - If `btn_s`=1, return to HELD_HIGH with count<=0.
  - Else if count==DEBOUNCE_CYCLES, go to IDLE_LOW with `btn_level`<=0. No selector change.
  - Else count++.
- **`sel_changed`:** registered; defaults to 0 every cycle unless set by an event; never high two cycles in a row.
- **Latency:** `btn_in` rising with no bounce → `clk_selector` update 2 sync cycles + DEBOUNCE_CYCLES+1 cycles later.
- **One step per press:** exactly one selector increment per debounced press regardless of hold length. Release never changes the selector.
- **Reset values (asynchronous, immediate):**
  - `clk_selector`=DEFAULT_SEL, `sel_changed`=0, `btn_level`=0.
  - State=IDLE_LOW, count=0, sync flip-flops=0.
- **Reset mid-debounce:** discards the pending press; no increment.
- **Button held through reset release:** counts as one new press after the full debounce.
- `clk_selector` only changes on the events above; it is glitch-free (straight from flip-flops).

Optional Feature:
- Macro: `SPEED_SEL_LONG_PRESS_EN`.
- **Defined:**
  - In HELD_HIGH with `btn_s`=1, count++ each cycle.
  - When count reaches LONG_PRESS_CYCLES: `clk_selector`<=DEFAULT_SEL and `sel_changed`<=1. This happens even if `clk_selector` already equals DEFAULT_SEL.
  - The counter then saturates, so the reset fires once per press.
  - The increment from the initial press still occurred earlier.
  - Bounce back through CHK_LOW → HELD_HIGH restarts the hold count at 0.
- **Undefined:** HELD_HIGH only waits for release, and LONG_PRESS_CYCLES has no effect.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, DEFAULT_SEL=00.
- Reset, then `btn_in`=1 held 30 cycles, then 0 → `clk_selector` 00→01 exactly 7 cycles after `btn_in` rises; one `sel_changed` pulse; `btn_level` falls 7 cycles after release.
- Four clean presses (each 10 high / 10 low) → `clk_selector` 01,10,11,00; four `sel_changed` pulses; wrap verified.
- Bounce: `btn_in` high 3 cycles, low 1, high 3, low → no `sel_changed`; `clk_selector` stays 00; `btn_level` stays 0.
- Release bounce: after an accepted press, release with 2-cycle low glitches before the final release → no extra increment; `btn_level` falls only after 5 consecutive low samples.
- Assert `rstn`=0 at count=3 of CHK_HIGH, then release reset with the button still high → `clk_selector`=00 during reset; exactly one increment to 01, 7 cycles after `rstn` rises.
- With `SPEED_SEL_LONG_PRESS_EN`: press from 10 and hold 40 cycles → increment to 11, then 20 cycles after entering HELD_HIGH, `clk_selector`=00 with a second single pulse, and no further pulses. Without the macro: only the 11 step.
